// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: digit width, decimal digit
// maximum, FSM state encodings and the per-digit clamp helper.
package bcd_pkg;
  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Out-of-range digit values saturate to the digit's maximum.
  function automatic logic [BCD_W-1:0] clamp(input logic [BCD_W-1:0] d,
                                             input logic [BCD_W-1:0] mx);
    return (d > mx) ? mx : d;
  endfunction
endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle of the BCD countdown timer.
//   master: drives load, load_bcd, start, halt, tick; observes bcd, K_end, done, running
//   slave : the timer itself
interface bcd_countdown_timer_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_bcd;
  logic                    start;
  logic                    halt;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    K_end;
  logic                    done;
  logic                    running;

  modport master (
    output load, load_bcd, start, halt, tick,
    input  bcd, K_end, done, running
  );

  modport slave (
    input  load, load_bcd, start, halt, tick,
    output bcd, K_end, done, running
  );
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// bcd_digit_down: one BCD down-counting digit.
//   clock, reset : rising-edge clock, async active-high reset (digit -> 0)
//   dec_in       : decrement request from the digit below (or the tick for digit 0)
//   load/load_val: synchronous load, wins over dec_in
//   max          : value the digit wraps to when decremented from 0
//   digit        : registered digit value
//   borrow_out   : decrement request passed to the next digit up
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_in,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       digit <= '0;
    else if (load)   digit <= load_val;
    else if (dec_in) digit <= (digit == '0) ? max : digit - 4'd1;
  end

  assign borrow_out = dec_in & (digit == '0);
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: cascaded multi-digit BCD down-counter with load,
// start/halt control, terminal flag and end-of-count pulse.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : load, load_bcd, start, halt, tick in; bcd, K_end, done, running out
// Parameters: NUM_DIGITS (1..8), MSD_MAX (1..9, max of the top digit).
// Optional feature macro BCD_COUNTDOWN_AUTO_RELOAD_EN: the terminal tick keeps
// the timer in RUN and the following tick reloads the last loaded value.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSD_MAX    = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  bcd_countdown_timer_if.slave    bus
);
  localparam logic [4*NUM_DIGITS-1:0] CNT_ONE = 1;

  state_t state_q, state_n;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] digits;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] digit_max;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] load_clamped;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] reload_val;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] digit_load_val;
  logic [NUM_DIGITS-1:0]            borrow;
  logic [NUM_DIGITS-1:0]            dec_in;

  logic adv;          // tick honoured this cycle
  logic count_zero;
  logic count_one;
  logic terminal;     // tick that takes the count from 1 to 0
  logic reload_now;   // tick arriving with the count already at 0
  logic digit_load;
  logic k_end_q;
  logic done_q;

  assign count_zero = (digits == '0);
  assign count_one  = (digits == CNT_ONE);

  // Load and halt outrank tick; start has no effect once running.
  assign adv      = (state_q == ST_RUN) & bus.tick & ~bus.load & ~bus.halt;
  assign terminal = adv & count_one;

  // The top digit's borrow only fires when a tick meets an all-zero count.
  // That is the auto-reload point; without auto-reload it is unreachable and
  // reloading zero simply pins the counter at 0 instead of wrapping.
  assign reload_now = borrow[NUM_DIGITS-1];

  assign digit_load     = bus.load | reload_now;
  assign digit_load_val = bus.load ? load_clamped : reload_val;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
      assign digit_max[i]    = (i == NUM_DIGITS-1) ? BCD_W'(MSD_MAX) : BCD_MAX;
      assign load_clamped[i] = clamp(bus.load_bcd[4*i +: 4], digit_max[i]);
      if (i == 0) begin : g_lsd
        assign dec_in[i] = adv;
      end else begin : g_upper
        assign dec_in[i] = borrow[i-1];
      end

      bcd_digit_down u_digit (
        .clock      (clock),
        .reset      (reset),
        .dec_in     (dec_in[i]),
        .load       (digit_load),
        .load_val   (digit_load_val[i]),
        .max        (digit_max[i]),
        .digit      (digits[i]),
        .borrow_out (borrow[i])
      );
    end
  endgenerate

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         reload_val <= '0;
    else if (bus.load) reload_val <= load_clamped;
  end
`else
  assign reload_val = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (bus.load) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start && !count_zero) state_n = ST_RUN;
        ST_RUN: begin
          if (bus.halt) state_n = ST_IDLE;
          // A zero reload value can never restart, so it stops like a one-shot.
          else if (terminal && reload_val == '0) state_n = ST_DONE;
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // K_end tracks the value the count will hold after this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_end_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= terminal;
      if (bus.load)        k_end_q <= (load_clamped == '0);
      else if (reload_now) k_end_q <= (reload_val == '0);
      else if (terminal)   k_end_q <= 1'b1;
    end
  end

  assign bus.bcd     = digits;
  assign bus.K_end   = k_end_q;
  assign bus.done    = done_q;
  assign bus.running = (state_q == ST_RUN);
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed testbench for bcd_countdown_timer: a 4-digit instance for the main
// sequences and a 2-digit instance with MSD_MAX=5 for clamp/wrap checks.
module tb_bcd_countdown_timer;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clock;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  bcd_countdown_timer_if #(.NUM_DIGITS(4)) b4 ();
  bcd_countdown_timer_if #(.NUM_DIGITS(2)) b2 ();

  bcd_countdown_timer #(.NUM_DIGITS(4), .MSD_MAX(9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (b4)
  );

  bcd_countdown_timer #(.NUM_DIGITS(2), .MSD_MAX(5)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (b2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One-cycle command on the 4-digit instance.
  task automatic drv(input logic ld, input logic [15:0] v, input logic st,
                     input logic hl, input logic tk);
    b4.load = ld; b4.load_bcd = v; b4.start = st; b4.halt = hl; b4.tick = tk;
    cyc();
    b4.load = 1'b0; b4.start = 1'b0; b4.halt = 1'b0; b4.tick = 1'b0;
  endtask

  task automatic drv2(input logic ld, input logic [7:0] v, input logic st, input logic tk);
    b2.load = ld; b2.load_bcd = v; b2.start = st; b2.halt = 1'b0; b2.tick = tk;
    cyc();
    b2.load = 1'b0; b2.start = 1'b0; b2.tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b4.load = 0; b4.load_bcd = '0; b4.start = 0; b4.halt = 0; b4.tick = 0;
    b2.load = 0; b2.load_bcd = '0; b2.start = 0; b2.halt = 0; b2.tick = 0;
    #12;
    check("rst_bcd", b4.bcd, 0);
    check("rst_kend", b4.K_end, 1);
    check("rst_run", b4.running, 0);
    check("rst_done", b4.done, 0);
    reset = 1'b0;
    cyc();

    // 1: asynchronous reset in the middle of a run
    drv(1, 16'h0042, 0, 0, 0);
    drv(0, 0, 1, 0, 0);
    check("t1_running", b4.running, 1);
    check("t1_bcd", b4.bcd, 16'h0042);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_bcd", b4.bcd, 0);
    check("t1_rst_kend", b4.K_end, 1);
    check("t1_rst_run", b4.running, 0);
    #1 reset = 1'b0;
    cyc();

    // start with zero count is ignored
    drv(0, 0, 1, 0, 0);
    check("zero_start_run", b4.running, 0);
    check("zero_start_done", b4.done, 0);

    // 2: 0x0100 counted all the way down
    drv(1, 16'h0100, 0, 0, 0);
    check("t2_load", b4.bcd, 16'h0100);
    check("t2_kend0", b4.K_end, 0);
    check("t2_idle", b4.running, 0);
    drv(0, 0, 0, 0, 1);
    check("t2_tick_idle", b4.bcd, 16'h0100);
    drv(0, 0, 1, 0, 0);
    check("t2_run", b4.running, 1);
    drv(0, 0, 0, 0, 1);
    check("t2_borrow", b4.bcd, 16'h0099);
    for (int k = 0; k < 98; k++) drv(0, 0, 0, 0, 1);
    check("t2_one", b4.bcd, 16'h0001);
    check("t2_nodone", b4.done, 0);
    check("t2_kend_one", b4.K_end, 0);
    drv(0, 0, 0, 0, 1);
    check("t2_zero", b4.bcd, 0);
    check("t2_done", b4.done, 1);
    check("t2_kend", b4.K_end, 1);
    check("t2_state", b4.running, AR);
    cyc();
    check("t2_done_pulse", b4.done, 0);

    // 5: DONE ignores start/tick (auto-reload instead reloads 0x0100)
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1);
    check("t5_bcd", b4.bcd, AR ? 32'h0100 : 32'h0);
    check("t5_run", b4.running, AR);
    check("t5_done", b4.done, 0);
    drv(1, 16'h0005, 0, 0, 0);
    check("t5_load", b4.bcd, 16'h0005);
    check("t5_kend", b4.K_end, 0);
    check("t5_idle", b4.running, 0);
    drv(0, 0, 1, 0, 0);
    check("t5_restart", b4.running, 1);
    drv(0, 0, 0, 1, 0);

    // clamp on the 4-digit instance
    drv(1, 16'hFA3C, 0, 0, 0);
    check("clamp4", b4.bcd, 16'h9939);

    // 4: halt pauses the count
    drv(1, 16'h0003, 0, 0, 0);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1);
    check("t4_tick", b4.bcd, 16'h0002);
    drv(0, 0, 0, 1, 0);
    check("t4_halt", b4.running, 0);
    for (int k = 0; k < 5; k++) drv(0, 0, 0, 0, 1);
    check("t4_held", b4.bcd, 16'h0002);
    drv(0, 0, 1, 0, 1);
    check("t4_start_only", b4.bcd, 16'h0002);
    check("t4_rerun", b4.running, 1);
    drv(0, 0, 0, 0, 1);
    check("t4_one", b4.bcd, 16'h0001);
    drv(0, 0, 0, 0, 1);
    check("t4_zero", b4.bcd, 0);
    check("t4_done", b4.done, 1);
    check("t4_state", b4.running, AR);

    // load wins over everything and clears done
    drv(1, 16'h0000, 1, 0, 1);
    check("ld_prio_bcd", b4.bcd, 0);
    check("ld_prio_run", b4.running, 0);
    check("ld_prio_kend", b4.K_end, 1);

    // 3: NUM_DIGITS=2, MSD_MAX=5
    drv2(1, 8'h9A, 0, 0);
    check("t3_clamp", b2.bcd, 8'h59);
    drv2(1, 8'h50, 0, 0);
    drv2(0, 0, 1, 0);
    drv2(0, 0, 0, 1);
    check("t3_wrap", b2.bcd, 8'h49);
    drv2(1, 8'h10, 0, 0);
    drv2(0, 0, 1, 0);
    drv2(0, 0, 0, 1);
    check("t3_wrap10", b2.bcd, 8'h09);

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    // 6: periodic reload
    drv(1, 16'h0002, 0, 0, 0);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1);
    check("t6_1", b4.bcd, 16'h0001);
    drv(0, 0, 0, 0, 1);
    check("t6_0", b4.bcd, 0);
    check("t6_done", b4.done, 1);
    check("t6_kend", b4.K_end, 1);
    check("t6_run0", b4.running, 1);
    drv(0, 0, 0, 0, 1);
    check("t6_reload", b4.bcd, 16'h0002);
    check("t6_kend_drop", b4.K_end, 0);
    check("t6_done_clr", b4.done, 0);
    drv(0, 0, 0, 0, 1);
    check("t6_1b", b4.bcd, 16'h0001);
    check("t6_run1", b4.running, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
